// File: rtl/alu_seq.sv
// Command-side sequencer for a combinational ALU; optional operand chaining under ALU_SEQ_CHAIN_EN.
// Latency: request accepted at edge k, response valid after edge k+1; one transaction in flight.
// Backpressure: req_ready only in IDLE; response held stable until res_valid&res_ready.
module alu_seq #(
    parameter int len_A = 4,
    parameter int len_B = 5,
    parameter int len_F = 5,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [len_A-1:0] req_a,
    input  logic [len_B-1:0] req_b,
`ifdef ALU_SEQ_CHAIN_EN
    input  logic             req_chain,
`endif
    output logic [len_A-1:0] alu_a,
    output logic [len_B-1:0] alu_b,
    output logic [2:0]       alu_op,
    input  logic [len_F-1:0] alu_f,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [len_F-1:0] res_data,
    output logic             res_err,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [len_A-1:0]   alu_a_q, alu_a_d;
    logic [len_B-1:0]   alu_b_q, alu_b_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic               err_q, err_d;
    logic               res_valid_q, res_valid_d;
    logic [len_F-1:0]   res_data_q, res_data_d;
    logic               res_err_q, res_err_d;
    logic [CNT_W-1:0]   done_cnt_q, done_cnt_d;
    logic [len_A-1:0]   next_a;

`ifdef ALU_SEQ_CHAIN_EN
    logic [len_F-1:0]   last_f_q, last_f_d;
    logic [len_A-1:0]   chain_a;

    // Previous result is truncated or zero-extended to fit operand A.
    if (len_F >= len_A) begin : g_chain_trunc
        assign chain_a = last_f_q[len_A-1:0];
    end else begin : g_chain_zext
        assign chain_a = {{(len_A-len_F){1'b0}}, last_f_q};
    end

    assign next_a = req_chain ? chain_a : req_a;
`else
    assign next_a = req_a;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = ISSUE;
            ISSUE:   state_d = RESP;
            RESP:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        req_ready = (state_q == IDLE);
    end

    // Datapath next values.
    always_comb begin
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_op_d    = alu_op_q;
        err_d       = err_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_err_d   = res_err_q;
        done_cnt_d  = done_cnt_q;
`ifdef ALU_SEQ_CHAIN_EN
        last_f_d    = last_f_q;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    alu_a_d  = next_a;
                    alu_b_d  = req_b;
                    alu_op_d = req_op;
                    err_d    = (req_op == 3'd0);
                end
            end
            ISSUE: begin
                res_data_d  = err_q ? '0 : alu_f;
                res_err_d   = err_q;
                res_valid_d = 1'b1;
`ifdef ALU_SEQ_CHAIN_EN
                if (!err_q) last_f_d = alu_f;
`endif
            end
            RESP: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    res_err_d   = 1'b0;
                    done_cnt_d  = done_cnt_q + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_err_q   <= 1'b0;
            done_cnt_q  <= '0;
`ifdef ALU_SEQ_CHAIN_EN
            last_f_q    <= '0;
`endif
        end else begin
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_op_q    <= alu_op_d;
            err_q       <= err_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_err_q   <= res_err_d;
            done_cnt_q  <= done_cnt_d;
`ifdef ALU_SEQ_CHAIN_EN
            last_f_q    <= last_f_d;
`endif
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;
    assign done_cnt  = done_cnt_q;

endmodule
